trap_sequencer: RTL and testbench
=================================

// Module: trap_sequencer
// PURPOSE
//  Multi-cycle trap-entry/exit controller between the pipeline's exception sources and the single-port CSR file.
//  Serialises trap entry: mepc, mcause, mtval writes, then an mtvec read; stalls/flushes the pipeline; redirects fetch.
//  Also sequences mret: mepc read, then redirect.
//  Sole owner of the CSR port while busy; the pipeline CSR path is muxed off with stall_o.
// PARAMETERS
//  XLEN        32      datapath width; only 32 is supported
//  CAUSE_W     4       width of exc_cause_i (RISC-V mcause exception code)
// PORTS
//  clk_i             in   1      clock; all state changes on rising edge
//  rst_i             in   1      synchronous, active-high reset
//  exc_valid_i       in   1      exception request from pipeline (level, held until exc_ready_o)
//  exc_cause_i       in   4      cause code: 0 instr-misaligned, 2 illegal, 4 load-misaligned, 6 store-misaligned
//  exc_pc_i          in   32     PC of faulting instruction
//  exc_tval_i        in   32     trap value (faulting address or instruction bits)
//  mret_i            in   1      mret retiring (level, held until exc_ready_o)
//  exc_ready_o       out  1      request accepted this cycle (exc or mret)
//  csr_addr_o        out  12     CSR address
//  csr_wdata_o       out  32     CSR write data
//  csr_we_o          out  1      CSR write enable
//  csr_rdata_i       in   32     CSR read data, combinational, same cycle as csr_addr_o
//  stall_o           out  1      pipeline hold; high whenever state != IDLE
//  flush_o           out  1      1-cycle pulse: squash IF..EX
//  redirect_valid_o  out  1      1-cycle pulse: load fetch PC
//  redirect_pc_o     out  32     target PC, valid with redirect_valid_o
// BEHAVIOUR
//  Reset:
//   - state=IDLE; all outputs 0; capture regs cleared.
//   - Reset mid-sequence aborts at once; no further CSR writes. Writes already done are not undone.
//  FSM: IDLE, W_MEPC, W_MCAUSE, W_MTVAL, R_MTVEC, R_MEPC, REDIRECT.
//  IDLE:
//   - exc_ready_o = exc_valid_i | mret_i (combinational).
//   - Accept: capture cause, pc, tval. Go to W_MEPC if exc_valid_i, else to R_MEPC if mret_i.
//   - exc_valid_i and mret_i both high: take the exception; drop mret (squashed).
//  Trap entry (one CSR op per cycle; csr_we_o=1 in the W_* states):
//   - W_MEPC:   addr=0x341, wdata={pc[31:2],2'b00}; flush_o=1
//   - W_MCAUSE: addr=0x342, wdata={28'b0,cause}; cause not in {0,2,4,6} -> written as 2
//   - W_MTVAL:  addr=0x343, wdata=tval
//   - R_MTVEC:  addr=0x305, we=0; latch {rdata[31:2],2'b00} into target (mode bits ignored)
//   - REDIRECT: redirect_valid_o=1, redirect_pc_o=target; next state IDLE
//  mret:
//   - R_MEPC: addr=0x341, we=0; latch {rdata[31:2],2'b00}; flush_o=1; then REDIRECT.
//  Latency, accept cycle = 0:
//   - Exception: redirect in cycle 5.
//   - mret: redirect in cycle 2.
//   - Next accept no earlier than the cycle after REDIRECT.
//  While not IDLE:
//   - exc_ready_o=0; new requests ignored (held by the requester).
//   - csr_* are 0 in IDLE and REDIRECT.
//  Width: no arithmetic; all CSR fields zero-extended to 32.
// TESTING
//  - Illegal instr, exc_cause_i=2, pc=0x0000_0040, tval=0x0000_0013, mtvec=0x0000_0101:
//    -> writes 0x341=0x40, 0x342=2, 0x343=0x13 in cycles 1-3; redirect_pc_o=0x100 in cycle 5; stall_o high cycles 1-5.
//  - mret with mepc=0x0000_0044:
//    -> R_MEPC cycle 1 (flush_o=1), redirect_pc_o=0x44 in cycle 2; no CSR writes.
//  - exc_valid_i and mret_i high together:
//    -> exception sequence only; mret never redirects.
//  - Second exc_valid_i asserted in cycle 2 of a sequence:
//    -> exc_ready_o=0 until IDLE; accepted in cycle 6; redirect in cycle 11.
//  - exc_cause_i=9:
//    -> mcause written as 2.
//  - rst_i high in W_MCAUSE:
//    -> next cycle IDLE, all outputs 0, no 0x343 write, no redirect.

Source files
------------

// File: rtl/trap_sequencer.sv
// trap_sequencer: serialises trap entry (mepc/mcause/mtval writes, mtvec read) and mret (mepc read),
// owning the CSR port while busy and redirecting fetch at the end of each sequence.
module trap_sequencer #(
    parameter int XLEN    = 32,
    parameter int CAUSE_W = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               exc_valid_i,
    input  logic [CAUSE_W-1:0] exc_cause_i,
    input  logic [XLEN-1:0]    exc_pc_i,
    input  logic [XLEN-1:0]    exc_tval_i,
    input  logic               mret_i,
    output logic               exc_ready_o,
    output logic [11:0]        csr_addr_o,
    output logic [XLEN-1:0]    csr_wdata_o,
    output logic               csr_we_o,
    input  logic [XLEN-1:0]    csr_rdata_i,
    output logic               stall_o,
    output logic               flush_o,
    output logic               redirect_valid_o,
    output logic [XLEN-1:0]    redirect_pc_o
);
    typedef enum logic [2:0] {IDLE, W_MEPC, W_MCAUSE, W_MTVAL, R_MTVEC, R_MEPC, REDIRECT} state_e;
    state_e             state_q, state_d;
    logic [CAUSE_W-1:0] cause_q, cause_d;
    logic [XLEN-1:0]    pc_q, pc_d, tval_q, tval_d, target_q, target_d;
    logic               cause_ok;
    assign cause_ok = cause_q inside {CAUSE_W'(0), CAUSE_W'(2), CAUSE_W'(4), CAUSE_W'(6)};
    assign stall_o  = (state_q != IDLE) && !rst_i;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cause_q  <= '0;
            pc_q     <= '0;
            tval_q   <= '0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            cause_q  <= cause_d;
            pc_q     <= pc_d;
            tval_q   <= tval_d;
            target_q <= target_d;
        end
    end
    // Outputs are forced low while reset is held so an aborted sequence issues no further writes.
    always_comb begin
        state_d          = state_q;
        cause_d          = cause_q;
        pc_d             = pc_q;
        tval_d           = tval_q;
        target_d         = target_q;
        exc_ready_o      = 1'b0;
        csr_addr_o       = 12'h000;
        csr_wdata_o      = '0;
        csr_we_o         = 1'b0;
        flush_o          = 1'b0;
        redirect_valid_o = 1'b0;
        redirect_pc_o    = '0;
        if (!rst_i) begin
            case (state_q)
                IDLE: begin
                    exc_ready_o = exc_valid_i | mret_i;
                    if (exc_ready_o) begin
                        cause_d = exc_cause_i;
                        pc_d    = exc_pc_i;
                        tval_d  = exc_tval_i;
                        state_d = exc_valid_i ? W_MEPC : R_MEPC;
                    end
                end
                W_MEPC: begin
                    csr_addr_o  = 12'h341;
                    csr_wdata_o = {pc_q[XLEN-1:2], 2'b00};
                    csr_we_o    = 1'b1;
                    flush_o     = 1'b1;
                    state_d     = W_MCAUSE;
                end
                W_MCAUSE: begin
                    csr_addr_o  = 12'h342;
                    csr_wdata_o = XLEN'(cause_ok ? cause_q : CAUSE_W'(2));
                    csr_we_o    = 1'b1;
                    state_d     = W_MTVAL;
                end
                W_MTVAL: begin
                    csr_addr_o  = 12'h343;
                    csr_wdata_o = tval_q;
                    csr_we_o    = 1'b1;
                    state_d     = R_MTVEC;
                end
                R_MTVEC: begin
                    csr_addr_o = 12'h305;
                    target_d   = {csr_rdata_i[XLEN-1:2], 2'b00};
                    state_d    = REDIRECT;
                end
                R_MEPC: begin
                    csr_addr_o = 12'h341;
                    target_d   = {csr_rdata_i[XLEN-1:2], 2'b00};
                    flush_o    = 1'b1;
                    state_d    = REDIRECT;
                end
                REDIRECT: begin
                    redirect_valid_o = 1'b1;
                    redirect_pc_o    = target_q;
                    state_d          = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_trap_sequencer.sv
// tb_trap_sequencer: directed scenarios for trap_sequencer with hand-computed per-cycle expectations.
module tb_trap_sequencer;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        exc_valid_i = 1'b0;
    logic [3:0]  exc_cause_i = '0;
    logic [31:0] exc_pc_i = '0;
    logic [31:0] exc_tval_i = '0;
    logic        mret_i = 1'b0;
    logic        exc_ready_o;
    logic [11:0] csr_addr_o;
    logic [31:0] csr_wdata_o;
    logic        csr_we_o;
    logic [31:0] csr_rdata_i;
    logic        stall_o;
    logic        flush_o;
    logic        redirect_valid_o;
    logic [31:0] redirect_pc_o;
    logic [31:0] mtvec_v = '0;
    logic [31:0] mepc_v = '0;
    int errors = 0;
    int checks = 0;

    trap_sequencer dut (
        .clk_i(clk_i), .rst_i(rst_i), .exc_valid_i(exc_valid_i), .exc_cause_i(exc_cause_i),
        .exc_pc_i(exc_pc_i), .exc_tval_i(exc_tval_i), .mret_i(mret_i), .exc_ready_o(exc_ready_o),
        .csr_addr_o(csr_addr_o), .csr_wdata_o(csr_wdata_o), .csr_we_o(csr_we_o),
        .csr_rdata_i(csr_rdata_i), .stall_o(stall_o), .flush_o(flush_o),
        .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o)
    );

    always #5 clk_i = ~clk_i;

    // Minimal CSR file: only mtvec and mepc are ever read.
    always_comb csr_rdata_i = (csr_addr_o == 12'h305) ? mtvec_v : (csr_addr_o == 12'h341) ? mepc_v : 32'h0;

    wire [79:0] obs = {stall_o, csr_we_o, csr_addr_o, csr_wdata_o, flush_o, redirect_valid_o, redirect_pc_o};

    function automatic logic [79:0] ev(input logic s, input logic we, input logic [11:0] a,
                                       input logic [31:0] d, input logic f, input logic rv, input logic [31:0] pc);
        return {s, we, a, d, f, rv, pc};
    endfunction

    task automatic step();
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        exc_valid_i = 1'b1;
        repeat (2) step();
        #1;
        checks++;
        if (obs !== 80'h0 || exc_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got obs=%h ready=%b want obs=0 ready=0", obs, exc_ready_o);
        end
        exc_valid_i = 1'b0;
        step();
        rst_i = 1'b0;
        #1;
        checks++;
        if (obs !== 80'h0 || exc_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got obs=%h ready=%b want obs=0 ready=0", obs, exc_ready_o);
        end
    endtask

    task automatic test_illegal();
        logic [79:0] e [1:6];
        mtvec_v = 32'h0000_0101;
        e[1] = ev(1, 1, 12'h341, 32'h40, 1, 0, 0);
        e[2] = ev(1, 1, 12'h342, 32'h2, 0, 0, 0);
        e[3] = ev(1, 1, 12'h343, 32'h13, 0, 0, 0);
        e[4] = ev(1, 0, 12'h305, 32'h0, 0, 0, 0);
        e[5] = ev(1, 0, 12'h000, 32'h0, 0, 1, 32'h100);
        e[6] = 80'h0;
        step();
        exc_valid_i = 1'b1; exc_cause_i = 4'd2; exc_pc_i = 32'h40; exc_tval_i = 32'h13;
        #1;
        checks++;
        if (exc_ready_o !== 1'b1 || stall_o !== 1'b0) begin
            errors++;
            $display("FAIL illegal_accept: got ready=%b stall=%b want ready=1 stall=0", exc_ready_o, stall_o);
        end
        for (int k = 1; k <= 6; k++) begin
            step();
            exc_valid_i = 1'b0;
            #1;
            checks++;
            if (obs !== e[k] || exc_ready_o !== 1'b0) begin
                errors++;
                $display("FAIL illegal_c%0d: got %h ready=%b want %h ready=0", k, obs, exc_ready_o, e[k]);
            end
        end
    endtask

    task automatic test_mret();
        logic [31:0] mepc_t [2] = '{32'h0000_0044, 32'h0000_1003};
        logic [31:0] want_t [2] = '{32'h0000_0044, 32'h0000_1000};
        for (int t = 0; t < 2; t++) begin
            mepc_v = mepc_t[t];
            step();
            mret_i = 1'b1;
            #1;
            checks++;
            if (exc_ready_o !== 1'b1) begin
                errors++;
                $display("FAIL mret%0d_accept: got ready=%b want 1", t, exc_ready_o);
            end
            step();
            mret_i = 1'b0;
            #1;
            checks++;
            if (obs !== ev(1, 0, 12'h341, 0, 1, 0, 0)) begin
                errors++;
                $display("FAIL mret%0d_c1: got %h want %h", t, obs, ev(1, 0, 12'h341, 0, 1, 0, 0));
            end
            step();
            #1;
            checks++;
            if (obs !== ev(1, 0, 12'h000, 0, 0, 1, want_t[t])) begin
                errors++;
                $display("FAIL mret%0d_c2: got %h want %h", t, obs, ev(1, 0, 12'h000, 0, 0, 1, want_t[t]));
            end
            step();
            #1;
            checks++;
            if (obs !== 80'h0) begin
                errors++;
                $display("FAIL mret%0d_c3: got %h want 0", t, obs);
            end
        end
    endtask

    task automatic test_both();
        logic [79:0] e [1:8];
        mtvec_v = 32'h0000_2002;
        mepc_v  = 32'h0000_0999;
        e[1] = ev(1, 1, 12'h341, 32'h200, 1, 0, 0);
        e[2] = ev(1, 1, 12'h342, 32'h4, 0, 0, 0);
        e[3] = ev(1, 1, 12'h343, 32'hDEAD_BEEF, 0, 0, 0);
        e[4] = ev(1, 0, 12'h305, 32'h0, 0, 0, 0);
        e[5] = ev(1, 0, 12'h000, 32'h0, 0, 1, 32'h2000);
        e[6] = 80'h0; e[7] = 80'h0; e[8] = 80'h0;
        step();
        exc_valid_i = 1'b1; mret_i = 1'b1;
        exc_cause_i = 4'd4; exc_pc_i = 32'h203; exc_tval_i = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (exc_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL both_accept: got ready=%b want 1", exc_ready_o);
        end
        for (int k = 1; k <= 8; k++) begin
            step();
            exc_valid_i = 1'b0; mret_i = 1'b0;
            #1;
            checks++;
            if (obs !== e[k]) begin
                errors++;
                $display("FAIL both_c%0d: got %h want %h", k, obs, e[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [79:0] e [1:12];
        logic        r [1:12];
        mtvec_v = 32'h0000_0300;
        e[1]  = ev(1, 1, 12'h341, 32'h100, 1, 0, 0);
        e[2]  = ev(1, 1, 12'h342, 32'h6, 0, 0, 0);
        e[3]  = ev(1, 1, 12'h343, 32'h55, 0, 0, 0);
        e[4]  = ev(1, 0, 12'h305, 32'h0, 0, 0, 0);
        e[5]  = ev(1, 0, 12'h000, 32'h0, 0, 1, 32'h300);
        e[6]  = 80'h0;
        e[7]  = ev(1, 1, 12'h341, 32'h80, 1, 0, 0);
        e[8]  = ev(1, 1, 12'h342, 32'h0, 0, 0, 0);
        e[9]  = ev(1, 1, 12'h343, 32'h81, 0, 0, 0);
        e[10] = ev(1, 0, 12'h305, 32'h0, 0, 0, 0);
        e[11] = ev(1, 0, 12'h000, 32'h0, 0, 1, 32'h404);
        e[12] = 80'h0;
        r = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
        step();
        exc_valid_i = 1'b1; exc_cause_i = 4'd6; exc_pc_i = 32'h100; exc_tval_i = 32'h55;
        #1;
        checks++;
        if (exc_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept0: got ready=%b want 1", exc_ready_o);
        end
        for (int k = 1; k <= 12; k++) begin
            step();
            exc_valid_i = (k >= 2 && k <= 6);
            if (k == 2) begin
                exc_cause_i = 4'd0; exc_pc_i = 32'h80; exc_tval_i = 32'h81;
            end
            if (k == 6) mtvec_v = 32'h0000_0404;
            #1;
            checks++;
            if (obs !== e[k] || exc_ready_o !== r[k]) begin
                errors++;
                $display("FAIL b2b_c%0d: got %h ready=%b want %h ready=%b", k, obs, exc_ready_o, e[k], r[k]);
            end
        end
    endtask

    task automatic test_cause9();
        step();
        exc_valid_i = 1'b1; exc_cause_i = 4'd9; exc_pc_i = 32'h0000_0010; exc_tval_i = 32'h0;
        step();
        exc_valid_i = 1'b0;
        step();
        #1;
        checks++;
        if (csr_addr_o !== 12'h342 || csr_wdata_o !== 32'h2 || csr_we_o !== 1'b1) begin
            errors++;
            $display("FAIL cause9_mcause: got addr=%h wdata=%h we=%b want addr=342 wdata=2 we=1",
                     csr_addr_o, csr_wdata_o, csr_we_o);
        end
        repeat (4) step();
        #1;
        checks++;
        if (obs !== 80'h0) begin
            errors++;
            $display("FAIL cause9_idle: got %h want 0", obs);
        end
    endtask

    task automatic test_reset_mid();
        mtvec_v = 32'h0000_0101;
        step();
        exc_valid_i = 1'b1; exc_cause_i = 4'd2; exc_pc_i = 32'h40; exc_tval_i = 32'h13;
        step();
        exc_valid_i = 1'b0;
        step();
        #1;
        checks++;
        if (obs !== ev(1, 1, 12'h342, 32'h2, 0, 0, 0)) begin
            errors++;
            $display("FAIL rstmid_mcause: got %h want %h", obs, ev(1, 1, 12'h342, 32'h2, 0, 0, 0));
        end
        rst_i = 1'b1;
        #1;
        checks++;
        if (obs !== 80'h0) begin
            errors++;
            $display("FAIL rstmid_held: got %h want 0", obs);
        end
        step();
        rst_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if (obs !== 80'h0 || exc_ready_o !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_c%0d: got %h ready=%b want 0 ready=0", k, obs, exc_ready_o);
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_illegal();
        test_mret();
        test_both();
        test_back_to_back();
        test_cause9();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
